// File: rtl/rename_stage.sv
// In-order register rename stage: RAT lookup, free-list allocation and a registered
// output slot toward the issue queue, with commit-side reclamation of stale tags.
module rename_stage #(
    parameter int NUM_ARCH_REGS     = 32,
    parameter int NUM_PHYSICAL_REGS = 64,
    parameter int FREE_DEPTH        = NUM_PHYSICAL_REGS - NUM_ARCH_REGS,
    parameter int FL_PTR_BITS       = $clog2(FREE_DEPTH),
    localparam int ARCH_BITS        = $clog2(NUM_ARCH_REGS),
    localparam int PHYS_BITS        = $clog2(NUM_PHYSICAL_REGS),
    localparam int CNT_BITS         = FL_PTR_BITS + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ARCH_BITS-1:0] arch_rs1,
    input  logic [ARCH_BITS-1:0] arch_rs2,
    input  logic [ARCH_BITS-1:0] arch_rd,
    input  logic                 rd_write,
    input  logic [6:0]           opcode_in,
    input  logic [31:0]          immediate_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PHYS_BITS-1:0] phys_rs1,
    output logic [PHYS_BITS-1:0] phys_rs2,
    output logic [PHYS_BITS-1:0] phys_dest,
    output logic [PHYS_BITS-1:0] old_phys_dest,
    output logic [6:0]           opcode,
    output logic [31:0]          immediate,
    input  logic                 free_valid,
    input  logic [PHYS_BITS-1:0] free_phys,
    output logic [CNT_BITS-1:0]  free_count,
    output logic                 free_overflow
);

    logic [PHYS_BITS-1:0]   rat [NUM_ARCH_REGS];
    logic [PHYS_BITS-1:0]   free_list [FREE_DEPTH];
    logic [FL_PTR_BITS-1:0] head;
    logic [FL_PTR_BITS-1:0] tail;
    logic                   accept;
    logic                   alloc;
    logic                   free_full;
    logic                   free_accept;

    // Stalls even non-writing instructions when the free list is empty, keeping
    // in_ready independent of the incoming instruction.
    assign free_full   = (free_count == CNT_BITS'(FREE_DEPTH));
    assign in_ready    = (!out_valid || out_ready) && (free_count != '0);
    assign accept      = in_valid && in_ready;
    assign alloc       = accept && rd_write && (arch_rd != '0);
    assign free_accept = free_valid && (free_phys != '0) && !free_full;

    // rat[0] is never written, so x0 sources always read physical register 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                rat[i] <= PHYS_BITS'(i);
            end
        end else if (alloc) begin
            rat[arch_rd] <= free_list[head];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < FREE_DEPTH; k++) begin
                free_list[k] <= PHYS_BITS'(NUM_ARCH_REGS + k);
            end
        end else if (free_accept) begin
            free_list[tail] <= free_phys;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head          <= '0;
            tail          <= '0;
            free_count    <= CNT_BITS'(FREE_DEPTH);
            free_overflow <= 1'b0;
        end else begin
            if (alloc) begin
                head <= head + FL_PTR_BITS'(1);
            end
            if (free_accept) begin
                tail <= tail + FL_PTR_BITS'(1);
            end
            case ({free_accept, alloc})
                2'b10:   free_count <= free_count + CNT_BITS'(1);
                2'b01:   free_count <= free_count - CNT_BITS'(1);
                default: free_count <= free_count;
            endcase
            if (free_valid && (free_phys != '0) && free_full) begin
                free_overflow <= 1'b1;
            end
        end
    end

    // Sources read the RAT before this instruction's own update lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            phys_rs1      <= '0;
            phys_rs2      <= '0;
            phys_dest     <= '0;
            old_phys_dest <= '0;
            opcode        <= '0;
            immediate     <= '0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            phys_rs1      <= rat[arch_rs1];
            phys_rs2      <= rat[arch_rs2];
            phys_dest     <= alloc ? free_list[head] : '0;
            old_phys_dest <= alloc ? rat[arch_rd] : '0;
            opcode        <= opcode_in;
            immediate     <= immediate_in;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rename_stage.sv
// Bench for rename_stage: a queue/array reference model predicts every renamed
// instruction, and a separate monitor compares them as they leave the stage.
module tb_rename_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  arch_rs1;
    logic [4:0]  arch_rs2;
    logic [4:0]  arch_rd;
    logic        rd_write;
    logic [6:0]  opcode_in;
    logic [31:0] immediate_in;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  phys_rs1;
    logic [5:0]  phys_rs2;
    logic [5:0]  phys_dest;
    logic [5:0]  old_phys_dest;
    logic [6:0]  opcode;
    logic [31:0] immediate;
    logic        free_valid;
    logic [5:0]  free_phys;
    logic [5:0]  free_count;
    logic        free_overflow;

    typedef struct {
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [5:0]  dest;
        logic [5:0]  old;
        logic [6:0]  op;
        logic [31:0] imm;
    } exp_t;

    exp_t exp_q[$];
    int   free_q[$];
    int   m_rat[32];
    logic m_out_valid;
    logic m_overflow;
    int   n_compared = 0;
    int   n_mismatched = 0;

    rename_stage dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .arch_rs1(arch_rs1), .arch_rs2(arch_rs2), .arch_rd(arch_rd),
        .rd_write(rd_write), .opcode_in(opcode_in), .immediate_in(immediate_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .phys_rs1(phys_rs1), .phys_rs2(phys_rs2),
        .phys_dest(phys_dest), .old_phys_dest(old_phys_dest),
        .opcode(opcode), .immediate(immediate),
        .free_valid(free_valid), .free_phys(free_phys),
        .free_count(free_count), .free_overflow(free_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rat[i] = i;
        free_q.delete();
        for (int k = 0; k < 32; k++) free_q.push_back(32 + k);
        exp_q.delete();
        m_out_valid = 1'b0;
        m_overflow  = 1'b0;
    endtask

    task automatic drive_idle();
        in_valid = 1'b0; arch_rs1 = '0; arch_rs2 = '0; arch_rd = '0; rd_write = 1'b0;
        opcode_in = '0; immediate_in = '0; out_ready = 1'b1; free_valid = 1'b0; free_phys = '0;
    endtask

    // Asserts reset between clock edges so the asynchronous clear is visible at once.
    task automatic do_reset();
        #3;
        reset_n = 1'b0;
        #1;
        check_output("async_reset_out_valid", out_valid, 0);
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One cycle: drive inputs, check handshake/status against the model, then advance the model.
    task automatic apply_stimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] rd, input logic wr, input logic ordy,
                                  input logic fv, input logic [5:0] fp);
        exp_t e;
        logic m_ready;
        logic acc;
        int   old_size;
        @(negedge clk);
        in_valid = v; arch_rs1 = rs1; arch_rs2 = rs2; arch_rd = rd; rd_write = wr;
        out_ready = ordy; free_valid = fv; free_phys = fp;
        opcode_in = 7'($urandom); immediate_in = $urandom;
        #1;
        m_ready = (!m_out_valid || ordy) && (free_q.size() != 0);
        check_output("in_ready", in_ready, m_ready);
        check_output("free_count", free_count, free_q.size());
        check_output("out_valid", out_valid, m_out_valid);
        check_output("free_overflow", free_overflow, m_overflow);
        acc = v && m_ready;
        old_size = free_q.size();
        if (acc) begin
            e.rs1 = 6'(m_rat[rs1]);
            e.rs2 = 6'(m_rat[rs2]);
            e.op  = opcode_in;
            e.imm = immediate_in;
            if (wr && rd != 0) begin
                e.dest = 6'(free_q.pop_front());
                e.old  = 6'(m_rat[rd]);
                m_rat[rd] = e.dest;
            end else begin
                e.dest = '0;
                e.old  = '0;
            end
            exp_q.push_back(e);
        end
        if (fv && fp != 0) begin
            if (old_size == 32) m_overflow = 1'b1;
            else free_q.push_back(fp);
        end
        m_out_valid = acc ? 1'b1 : (ordy ? 1'b0 : m_out_valid);
    endtask

    task automatic idle_step();
        apply_stimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 6'd0);
    endtask

    task automatic alloc_step(input logic fv, input logic [5:0] fp);
        apply_stimulus(1'b1, 5'($urandom), 5'($urandom), 5'($urandom_range(1, 31)), 1'b1, 1'b1, fv, fp);
    endtask

    // Monitor: every output transfer pops the oldest predicted instruction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_output: got phys_dest %0d, expected no output", phys_dest);
                end else begin
                    e = exp_q.pop_front();
                    check_output("phys_rs1", phys_rs1, e.rs1);
                    check_output("phys_rs2", phys_rs2, e.rs2);
                    check_output("phys_dest", phys_dest, e.dest);
                    check_output("old_phys_dest", old_phys_dest, e.old);
                    check_output("opcode", opcode, e.op);
                    check_output("immediate", immediate, e.imm);
                end
            end
        end
    end

    initial begin
        drive_idle();
        do_reset();

        $display("[TB] basic rename after reset");
        check_output("reset_free_count", free_count, 32);
        check_output("reset_out_valid", out_valid, 0);
        apply_stimulus(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 6'd0);
        idle_step();
        check_output("first_phys_dest", phys_dest, 32);
        check_output("first_old_dest", old_phys_dest, 5);
        check_output("first_phys_rs1", phys_rs1, 5);
        check_output("first_phys_rs2", phys_rs2, 0);
        check_output("first_free_count", free_count, 31);

        $display("[TB] back-to-back dependency");
        do_reset();
        apply_stimulus(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 6'd0);
        apply_stimulus(1'b1, 5'd3, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 6'd0);
        idle_step();
        check_output("dep_phys_rs1", phys_rs1, 32);
        check_output("dep_old_dest", old_phys_dest, 32);
        check_output("dep_phys_dest", phys_dest, 33);

        $display("[TB] free-list exhaustion and refill");
        do_reset();
        repeat (32) alloc_step(1'b0, 6'd0);
        idle_step();
        check_output("empty_free_count", free_count, 0);
        check_output("empty_in_ready", in_ready, 0);
        apply_stimulus(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1, 6'd7);
        check_output("refill_same_cycle_ready", in_ready, 0);
        apply_stimulus(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 6'd0);
        idle_step();
        check_output("refill_phys_dest", phys_dest, 7);

        $display("[TB] back-pressure hold and drain");
        do_reset();
        apply_stimulus(1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0, 6'd0);
        for (int c = 0; c < 5; c++) begin
            apply_stimulus(1'b1, 5'($urandom), 5'($urandom), 5'd9, 1'b1, 1'b0, 1'b0, 6'd0);
            check_output("hold_phys_dest", phys_dest, 32);
            check_output("hold_old_dest", old_phys_dest, 6);
            check_output("hold_free_count", free_count, 31);
        end
        apply_stimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 6'd0);
        idle_step();
        check_output("drain_out_valid", out_valid, 0);

        $display("[TB] simultaneous alloc/free and pointer wrap");
        do_reset();
        repeat (22) alloc_step(1'b0, 6'd0);
        alloc_step(1'b1, 6'($urandom_range(1, 63)));
        idle_step();
        check_output("simul_free_count", free_count, 10);
        repeat (40) alloc_step(1'b1, 6'($urandom_range(1, 63)));
        idle_step();
        check_output("wrap_free_count", free_count, 10);

        $display("[TB] x0 destination and overflow");
        do_reset();
        apply_stimulus(1'b1, 5'd7, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 6'd0);
        idle_step();
        check_output("x0_phys_dest", phys_dest, 0);
        check_output("x0_old_dest", old_phys_dest, 0);
        check_output("x0_free_count", free_count, 32);
        apply_stimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 6'd9);
        idle_step();
        check_output("overflow_flag", free_overflow, 1);
        check_output("overflow_free_count", free_count, 32);

        $display("[TB] randomized traffic");
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            apply_stimulus(($urandom % 4) != 0, 5'($urandom), 5'($urandom), 5'($urandom),
                           ($urandom % 4) != 0, ($urandom % 4) != 0,
                           ($urandom % 3) == 0, 6'($urandom_range(1, 63)));
        end

        $display("[TB] reset mid-stream");
        apply_stimulus(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 6'd0);
        apply_stimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd0);
        check_output("pre_reset_out_valid", out_valid, 1);
        do_reset();
        apply_stimulus(1'b1, 5'd5, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 6'd0);
        idle_step();
        check_output("identity_rs1", phys_rs1, 5);
        check_output("identity_rs2", phys_rs2, 9);
        check_output("identity_free_count", free_count, 32);

        repeat (3) idle_step();
        check_output("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- In-order register rename stage sitting directly upstream of the issue queue. One instruction per cycle.
- Maps architectural rs1/rs2/rd to physical registers using a register alias table (RAT) and a circular free-list FIFO.
- Presents a registered renamed instruction to the issue queue; the issue queue's full flag acts as back-pressure.
- Reclaims stale physical registers when the ROB commits.

Parameters:
NUM_ARCH_REGS, 32, architectural registers (x0 hardwired zero)
NUM_PHYSICAL_REGS, 64, physical registers; 6-bit tags
FREE_DEPTH, NUM_PHYSICAL_REGS-NUM_ARCH_REGS (32), free-list capacity
FL_PTR_BITS, $clog2(FREE_DEPTH) (5), free-list pointer width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  decoded instruction valid
in_ready  out  1  stage accepts instruction this cycle
arch_rs1  in  5  source 1 architectural register
arch_rs2  in  5  source 2 architectural register
arch_rd  in  5  destination architectural register
rd_write  in  1  instruction writes rd
opcode_in  in  7  passthrough
immediate_in  in  32  passthrough
out_valid  out  1  renamed instruction valid (registered)
out_ready  in  1  downstream accepts; tie to !issue_queue_full
phys_rs1  out  6  renamed source 1
phys_rs2  out  6  renamed source 2
phys_dest  out  6  allocated destination; 0 if no allocation
old_phys_dest  out  6  previous mapping of rd, for ROB; 0 if no allocation
opcode  out  7  registered opcode_in
immediate  out  32  registered immediate_in
free_valid  in  1  commit frees a physical register
free_phys  in  6  physical register to free
free_count  out  6  entries in free list (0..32)
free_overflow  out  1  sticky: free_valid while free list full

Behaviour:
- Clock and reset: single clock, clk. reset_n is asynchronous active-low. All state is reset on negedge reset_n, independent of clk.
- Reset values:
  - RAT[i]=i for all i.
  - Free-list slot k holds 32+k; head=0, tail=0, free_count=32.
  - out_valid=0; phys_rs1, phys_rs2, phys_dest, old_phys_dest, opcode, immediate all 0.
  - free_overflow=0.
- Reset asserted mid-operation discards the output register and any in-flight allocation. No partial state survives.
- in_ready = (!out_valid || out_ready) && (free_count != 0).
  - Combinational from registered state and out_ready only; it does not depend on in_valid, rd_write or arch_rd.
  - This is conservative: a non-writing instruction also stalls when the free list is empty.
- Accept = in_valid && in_ready. On accept, at the next rising edge:
  - out_valid<=1.
  - phys_rs1<=RAT[arch_rs1], phys_rs2<=RAT[arch_rs2], read before this instruction's own RAT update. rd==rs1 therefore yields the old mapping.
  - x0 sources always yield phys 0; RAT[0] is never written.
  - If alloc = rd_write && arch_rd!=0:
    - phys_dest<=freelist[head], old_phys_dest<=RAT[arch_rd].
    - RAT[arch_rd]<=freelist[head], head<=head+1 (mod 32, natural wrap).
  - Otherwise phys_dest<=0, old_phys_dest<=0, and RAT, head and count are unchanged.
- Latency: 1 cycle, accept to out_valid. The next accepted instruction sees the updated RAT; no bypass is required.
- Output hold: if out_valid && !out_ready, all outputs hold and in_ready=0.
- Output drain: if out_valid && out_ready and no accept, out_valid<=0 next edge.
- Free path: if free_valid, then freelist[tail]<=free_phys and tail<=tail+1 (mod 32).
  - free_phys==0 is ignored.
  - free_valid while free_count==32 is dropped and sets free_overflow (sticky until reset). Head, tail and count are unchanged.
- free_count update per cycle: +1 for each accepted free, -1 for each allocation, net 0 when both occur.
  - A free arriving when free_count==0 does not raise in_ready in that same cycle; the stage accepts the following cycle.
  - The free list never underflows, because in_ready gates allocation on free_count!=0.

Test Plan:
- Reset then idle: free_count=32, out_valid=0. Accept add rd=5, rs1=5, rs2=0 -> next cycle phys_dest=32, old_phys_dest=5, phys_rs1=5, phys_rs2=0, free_count=31.
- Back-to-back dependency: rd=3 then rs1=3 in consecutive cycles -> second instruction phys_rs1=32 (first allocation); second instruction's rd=3 gives old_phys_dest=32, phys_dest=33.
- Exhaustion: 32 allocating instructions with out_ready=1 -> free_count=0, in_ready=0.
  - Then free_valid with free_phys=7 -> free_count=1; in_ready rises the following cycle; the next allocation gets phys_dest=7.
- Back-pressure: out_ready=0 with a pending output -> outputs stable, in_ready=0, RAT and head unchanged for 5 cycles. Release -> drains in 1 cycle.
- Simultaneous alloc+free at free_count=10 -> free_count stays 10. Wrap: 40 alloc/free pairs -> head and tail wrap past 31, allocation order correct.
- Edge cases:
  - rd=0 with rd_write=1 -> phys_dest=0, count unchanged.
  - free_valid at count=32 -> free_overflow=1, count stays 32.
  - reset_n low mid-stream -> out_valid=0 immediately, RAT reset to identity.
